// File: rtl/board_port_arbiter.sv
// Four-way round-robin arbiter for the shared Conway board write port.
// Grants are held until release or preempted after MAX_HOLD cycles while others wait.
module board_port_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [1:0] grant_idx,
  output logic [3:0] grant_onehot
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [1:0]       idx_n;
  logic [1:0]       winner;
  logic             found;
  logic             release_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_cnt_n;
      grant_idx <= idx_n;
    end
  end

  assign grant_valid  = (state == GRANT);
  assign grant_onehot = grant_valid ? (4'b0001 << grant_idx) : '0;

  // Rotating priority search starting at ptr.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        winner = ptr + 2'(i);
        found  = 1'b1;
      end
    end
  end

  // done and preemption collapse into a single release so ptr advances once.
  assign release_now = done || !req[grant_idx] ||
                       ((hold_cnt == HOLD_LAST) && ((req & ~grant_onehot) != 4'b0000));

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;
    idx_n      = grant_idx;
    case (state)
      IDLE: begin
        if (found) begin
          idx_n      = winner;
          hold_cnt_n = '0;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_n = IDLE;
          ptr_n   = grant_idx + 2'd1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_board_port_arbiter.sv
// Directed bench for board_port_arbiter with MAX_HOLD=4.
module tb_board_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [3:0] grant_onehot;

  int n_cmp  = 0;
  int n_fail = 0;

  board_port_arbiter #(.MAX_HOLD(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      obs = {grant_valid, grant_idx, grant_onehot};
      n_cmp++;
      if (obs !== 7'b0_00_0000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, 7'b0_00_0000);
      end
    end
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    obs = {grant_valid, grant_idx, grant_onehot};
    n_cmp++;
    if (obs !== 7'b1_10_0100) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b expected %b", obs, 7'b1_10_0100);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_rotation();
    logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [6:0] obs;
    logic [6:0] exp;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      obs = {grant_valid, grant_idx, grant_onehot};
      exp = {1'b1, exp_idx[k], 4'b0001 << exp_idx[k]};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rotation_grant[%0d]: got %b expected %b", k, obs, exp);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_cmp++;
      if ({grant_valid, grant_onehot} !== 5'b0_0000) begin
        n_fail++;
        $display("FAIL rotation_bubble[%0d]: got %b expected %b", k,
                 {grant_valid, grant_onehot}, 5'b0_0000);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_preempt();
    logic exp_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] exp_i [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    do_reset();
    req = 4'b0001;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (e == 1) req = 4'b0101;
      n_cmp++;
      if ({grant_valid, grant_idx} !== {exp_v[e], exp_i[e]}) begin
        n_fail++;
        $display("FAIL preempt_edge[%0d]: got v=%b idx=%0d expected v=%b idx=%0d",
                 e, grant_valid, grant_idx, exp_v[e], exp_i[e]);
      end
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_sole_holder();
    int bad = 0;
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 25; c++) begin
      tick();
      if (!(grant_valid === 1'b1 && grant_idx === 2'd0)) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL sole_holder: got %0d dropped cycles expected 0", bad);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b1010;
    tick();
    n_cmp++;
    if ({grant_valid, grant_idx} !== 3'b1_11) begin
      n_fail++;
      $display("FAIL drop_hold: got v=%b idx=%0d expected v=1 idx=3", grant_valid, grant_idx);
    end
    req = 4'b0010;
    tick();
    n_cmp++;
    if ({grant_valid, grant_idx, grant_onehot} !== 7'b0_11_0000) begin
      n_fail++;
      $display("FAIL drop_bubble: got %b expected %b",
               {grant_valid, grant_idx, grant_onehot}, 7'b0_11_0000);
    end
    tick();
    n_cmp++;
    if ({grant_valid, grant_idx, grant_onehot} !== 7'b1_01_0010) begin
      n_fail++;
      $display("FAIL drop_next_grant: got %b expected %b",
               {grant_valid, grant_idx, grant_onehot}, 7'b1_01_0010);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_done_idle();
    do_reset();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++;
    if ({grant_valid, grant_idx, grant_onehot} !== 7'b0_00_0000) begin
      n_fail++;
      $display("FAIL done_idle_state: got %b expected %b",
               {grant_valid, grant_idx, grant_onehot}, 7'b0_00_0000);
    end
    req = 4'b1111;
    tick();
    n_cmp++;
    if ({grant_valid, grant_idx} !== 3'b1_00) begin
      n_fail++;
      $display("FAIL done_idle_ptr: got v=%b idx=%0d expected v=1 idx=0", grant_valid, grant_idx);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0000;
    tick();
  endtask

  task automatic test_done_and_preempt();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0011;
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++;
    if (grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL coincide_bubble: got v=%b expected v=0", grant_valid);
    end
    tick();
    n_cmp++;
    if ({grant_valid, grant_idx} !== 3'b1_01) begin
      n_fail++;
      $display("FAIL coincide_next: got v=%b idx=%0d expected v=1 idx=1", grant_valid, grant_idx);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b1110;
    tick();
    n_cmp++;
    if ({grant_valid, grant_idx} !== 3'b1_10) begin
      n_fail++;
      $display("FAIL midrst_setup: got v=%b idx=%0d expected v=1 idx=2", grant_valid, grant_idx);
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({grant_valid, grant_onehot} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL midrst_drop: got %b expected %b", {grant_valid, grant_onehot}, 5'b0_0000);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({grant_valid, grant_idx, grant_onehot} !== 7'b1_01_0010) begin
      n_fail++;
      $display("FAIL midrst_regrant: got %b expected %b",
               {grant_valid, grant_idx, grant_onehot}, 7'b1_01_0010);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    test_reset();
    test_rotation();
    test_preempt();
    test_sole_holder();
    test_req_drop();
    test_done_idle();
    test_done_and_preempt();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/board_port_arbiter.md
Name: board_port_arbiter

Overview:
- 4-requester round-robin arbiter for the shared Conway board write port.
- Produces a registered 2-bit grant index and a one-hot grant vector. Index bit 0 maps to one-hot bit 0.
- A grant is held until the grantee releases it or is preempted after MAX_HOLD cycles.
- Sits between the four row-update engines and the board memory.

Parameters:
- MAX_HOLD, 8: maximum grant cycles while another requester waits. Legal range 2..256. Counter width is $clog2(MAX_HOLD).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  4  request per requester; level-sensitive.
- done  input  1  grantee release pulse; ignored when grant_valid is 0.
- grant_valid  output  1  a grant is active.
- grant_idx  output  2  index of the current grantee.
- grant_onehot  output  4  equals 1<<grant_idx when grant_valid is 1, otherwise 4'b0000.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=IDLE, ptr=0, hold_cnt=0.
  - grant_valid=0, grant_idx=2'b00, grant_onehot=4'b0000.
  - Reset applied mid-grant drops the grant at that edge. No release side effects; ptr returns to 0.
- State IDLE:
  - If req!=0 at an edge, the winner is the first set bit searching ptr, ptr+1, ... mod 4.
  - At that edge: grant_idx=winner, grant_valid=1, hold_cnt=0, state moves to GRANT.
  - Latency is one edge from req being sampled to grant_valid=1.
  - If req==0, remain in IDLE with all outputs 0.
- State GRANT, evaluated each edge in priority order:
  1. Release: done=1 or req[grant_idx]=0. Then grant_valid=0, ptr=grant_idx+1 mod 4, state moves to IDLE.
  2. Preempt: hold_cnt==MAX_HOLD-1 and (req & ~grant_onehot)!=0. Same updates as release.
  3. Otherwise stay in GRANT.
     - hold_cnt increments, saturating at MAX_HOLD-1.
     - grant_idx is unchanged.
- One-cycle bubble: after any release or preempt, grant_valid is 0 for exactly one cycle before the next grant. This is a hard requirement for board memory write turnaround.
- A sole requester may hold the grant indefinitely. hold_cnt saturates and preemption only fires once another request appears.
- Preempted requester: it may re-request. It is served after the others in round-robin order.
- Simultaneous done and preempt condition: treated as one release. ptr is updated exactly once.
- grant_idx holds its last value while grant_valid=0. Consumers must qualify it with grant_valid. grant_onehot is forced to 0 in this case.
- grant_onehot is driven combinationally from the registered grant_idx and grant_valid. No extra latency.

Test Plan:
- Reset, single request:
  - Stimulus: hold rst_n=0 for 2 edges with req=4'b1111, then release reset with req=4'b0100.
  - Required: outputs 0 during reset. After the first edge with rst_n=1, grant_valid=1, grant_idx=2, grant_onehot=4'b0100.
- Round-robin rotation:
  - Stimulus: req=4'b1111 continuously; each grantee pulses done one cycle after being granted.
  - Required: grant_idx sequence 0,1,2,3,0. Each grant is separated by exactly one grant_valid=0 cycle.
- Preemption (MAX_HOLD=4):
  - Stimulus: req=4'b0001, granted; at grant cycle 1 assert req[2].
  - Required: grant 0 held for 4 cycles, then grant_valid=0 for one cycle, then grant_idx=2.
  - With req=4'b0001 only, the grant persists for more than 20 cycles.
- Release by request drop:
  - Stimulus: grantee 3 deasserts req[3] mid-grant while req[1]=1.
  - Required: grant_valid=0 on the next edge, then grant_idx=1. Next search starts at ptr=0, wraps from 3.
- done while idle:
  - Stimulus: pulse done with req=0.
  - Required: no state change; ptr unchanged, verified by the next grant order.
- Reset mid-grant:
  - Stimulus: rst_n=0 for one edge while grant_idx=2 is active and req=4'b1110.
  - Required: grant_valid=0 and grant_onehot=0 at that edge. After reset releases, grant_idx=1 because ptr is 0 and req[0]=0.
